filter_compact_pack: RTL and testbench
======================================

Name: filter_compact_pack

Overview:
- Parametrised successor to the fixed 4-lane valid-word compaction filter.
- Compacts valid lanes of each input beat toward lane 0 in original lane order, then packs the compacted words across beats into dense full-width output beats.
- Full valid/ready backpressure on both sides; flushes a partial tail beat on last input.
- Sits between the edge-relaxation datapath and the frontier-write stage of the SSSP engine.

Parameters:
- LANES, 4, lanes per beat; power of 2, range 2..16.
- WIDTH, 64, bits per lane word.
- CNTW, $clog2(LANES+1), width of the valid-word count field (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat present
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_mask  in  LANES  per-lane word valid
- in_data  in  LANES*WIDTH  lane i at bits [i*WIDTH +: WIDTH]
- in_last  in  1  final beat of the stream
- out_valid  out  1  output beat present
- out_ready  in  1  downstream accept
- out_data  out  LANES*WIDTH  packed words, lanes 0..out_count-1 meaningful; lanes at or above out_count are 0
- out_count  out  CNTW  number of valid words, 0..LANES
- out_last  out  1  final beat of the stream

Behaviour:
- Stage C (compaction register):
  - On accept, registers the compacted words, popcount(in_mask) and in_last.
  - Lane order is preserved: the lowest set mask bit maps to lane 0.
- Packer: a residual buffer R holds 0..LANES-1 words. Residual words precede C words in output order.
- Stage O (output register):
  - Holds one beat until out_valid && out_ready.
  - out_valid, out_count, out_data and out_last are stable while stalled.
- Latency: an accepted beat that completes an output beat appears on out_valid 2 cycles after acceptance when there is no stall.
- in_ready: deasserted while rst is high. Otherwise asserted when C is empty, or when C is consumed in the same cycle. It is combinational from state and out_ready only, never from in_valid.
- C is consumed when O is free or draining, and the FSM is in RUN. Let T = |R| + cnt(C):
  - T < LANES, not last: append C to R; no output beat.
  - T >= LANES, not last: emit the first LANES words as a full beat; the remaining T-LANES words go to R.
  - Last, T <= LANES: emit all T words, out_last=1. Clear R.
  - Last, T = 0: emit an empty beat, out_count=0, out_last=1.
  - Last, T > LANES: emit a full beat with out_last=0, store T-LANES words in R, and go to FLUSH.
- FSM states:
  - RUN: normal operation.
  - FLUSH: in_ready=0. When O is free, emit R as a beat with out_last=1, clear R, return to RUN.
- Exact multiple of LANES on last: the last full beat carries out_last=1. No trailing empty beat.
- Beats with an all-zero mask and in_last=0 are absorbed and produce no output.
- Reset, including mid-stream:
  - out_valid=0, out_last=0, out_count=0, out_data=0.
  - R is emptied, C is invalidated, FSM returns to RUN.
  - All in-flight words are discarded.
- Arithmetic:
  - All counts are CNTW bits wide.
  - T uses CNTW+1 bits; it never exceeds 2*LANES-1.
  - Word selection uses an exclusive prefix popcount of the mask.

Decomposition:
- Package filter_pkg:
  - function popcount.
  - FSM state enum fsm_e {RUN, FLUSH}.
  - Parametrised helper for lane slicing.
- Sub-module lane_compactor, combinational, parameters LANES and WIDTH:
  - Inputs: mask, data. Outputs: compacted data, count.
  - Implemented as a prefix-sum mux network.
  - Instantiated once, ahead of stage C.

Test Plan:
- LANES=4: three beats.
  - Stimulus: mask 0101 (a0,a2); mask 1111 (b0..b3); mask 0001 (c0) with last.
  - Required response: beat {a0,a2,b0,b1} count 4, then beat {b2,b3,c0} count 3 last=1.
- Overflow on last.
  - Stimulus: mask 0111 (x0..x2), then mask 1111 (y0..y3) with last.
  - Required response: {x0,x1,x2,y0} count 4 last=0, then {y1,y2,y3} count 3 last=1.
  - in_ready=0 while in FLUSH.
- Empty last.
  - Stimulus: single beat, mask 0000 with last, R empty.
  - Required response: one beat with count 0, last=1, out_data all zero.
- Exact multiple.
  - Stimulus: mask 1111 twice, last on the second beat.
  - Required response: exactly two full beats, last=1 on the second only.
- Backpressure.
  - Stimulus: out_ready=0 for 10 cycles while 6 random-mask beats are offered.
  - Required response: in_ready drops once C and O are full. Outputs stay stable. After release, word order and counts match the reference model with no loss or duplication.
- Reset mid-stream.
  - Stimulus: assert rst for 1 cycle with R holding 2 words and O valid.
  - Required response: next cycle out_valid=0, out_count=0. A fresh stream of mask 1111 with last yields a single beat containing only the new words.

Source files
------------

// File: rtl/filter_compact_pack_pkg.sv
// Shared helpers for the compact/pack filter: lane popcount, FSM encoding, lane slicing.
package filter_pkg;

  localparam int MAX_LANES = 16;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fsm_e;

  function automatic logic [4:0] popcount(input logic [MAX_LANES-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < MAX_LANES; i++) n = n + 5'(v[i]);
    return n;
  endfunction

  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/filter_compact_pack_if.sv
// Input/output beat streams of the compact/pack filter, both valid/ready handshaked.
interface filter_compact_pack_if #(
  parameter int LANES = 4,
  parameter int WIDTH = 64,
  parameter int CNTW  = $clog2(LANES + 1)
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES-1:0]       in_mask;
  logic [LANES*WIDTH-1:0] in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_data;
  logic [CNTW-1:0]        out_count;
  logic                   out_last;

  modport master (
    output in_valid, in_mask, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_last
  );

  modport slave (
    input  in_valid, in_mask, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_last
  );
endinterface

// File: rtl/filter_compact_pack_lane_compactor.sv
// Combinational compaction of masked lanes toward lane 0, preserving lane order.
module lane_compactor
  import filter_pkg::*;
#(
  parameter int LANES = 4,
  parameter int WIDTH = 64,
  parameter int CNTW  = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0]       mask,
  input  logic [LANES*WIDTH-1:0] data,
  output logic [LANES*WIDTH-1:0] cdata,
  output logic [CNTW-1:0]        count
);

  logic [CNTW-1:0] pos [LANES];

  // pos[i] is the number of valid lanes below i, i.e. the output slot of lane i
  always_comb begin
    for (int i = 0; i < LANES; i++)
      pos[i] = CNTW'(popcount(MAX_LANES'(mask & ((LANES'(1) << i) - LANES'(1)))));
  end

  always_comb begin
    cdata = '0;
    for (int j = 0; j < LANES; j++)
      for (int i = j; i < LANES; i++)
        if (mask[i] && pos[i] == CNTW'(j))
          cdata[lane_lo(j, WIDTH) +: WIDTH] = cdata[lane_lo(j, WIDTH) +: WIDTH]
                                              | data[lane_lo(i, WIDTH) +: WIDTH];
  end

  assign count = CNTW'(popcount(MAX_LANES'(mask)));

endmodule

// File: rtl/filter_compact_pack.sv
// Compacts valid lanes per beat, then packs words across beats into dense output beats.
module filter_compact_pack
  import filter_pkg::*;
#(
  parameter int LANES = 4,
  parameter int WIDTH = 64,
  parameter int CNTW  = $clog2(LANES + 1)
) (
  input logic                 clk,
  input logic                 rst,
  filter_compact_pack_if.slave bus
);

  localparam int         TW      = CNTW + 1;
  localparam logic [0:0] S_RUN   = RUN;
  localparam logic [0:0] S_FLUSH = FLUSH;

  logic [LANES*WIDTH-1:0] cdata;
  logic [CNTW-1:0]        ccount;

  logic                   vld_p1;
  logic [LANES*WIDTH-1:0] c_data_p1;
  logic [CNTW-1:0]        c_cnt_p1;
  logic                   c_last_p1;

  logic                   vld_p2;
  logic [LANES*WIDTH-1:0] data_p2;
  logic [CNTW-1:0]        cnt_p2;
  logic                   last_p2;

  logic [WIDTH-1:0]       r_data [LANES];
  logic [CNTW-1:0]        r_cnt;
  logic [0:0]             state;

  logic                   in_ready;
  logic                   accept;
  logic                   o_free;
  logic                   consume;
  logic [TW-1:0]          total;
  logic [WIDTH-1:0]       comb_w [2*LANES];

  logic                   emit;
  logic [LANES*WIDTH-1:0] e_data;
  logic [CNTW-1:0]        e_cnt;
  logic                   e_last;
  logic                   r_load;
  logic [WIDTH-1:0]       r_nxt [LANES];
  logic [CNTW-1:0]        r_cnt_nxt;
  logic [0:0]             state_nxt;

  lane_compactor #(.LANES(LANES), .WIDTH(WIDTH), .CNTW(CNTW)) u_compactor (
    .mask  (bus.in_mask),
    .data  (bus.in_data),
    .cdata (cdata),
    .count (ccount)
  );

  assign o_free   = !vld_p2 || bus.out_ready;
  assign consume  = vld_p1 && o_free && (state == S_RUN);
  assign in_ready = !rst && (state == S_RUN) && (!vld_p1 || consume);
  assign accept   = bus.in_valid && in_ready;
  assign total    = TW'(r_cnt) + TW'(c_cnt_p1);

  // Residual words first, then stage C words; slots beyond the total stay zero
  always_comb begin
    for (int k = 0; k < 2*LANES; k++) comb_w[k] = '0;
    for (int k = 0; k < LANES; k++)
      if (CNTW'(k) < r_cnt) comb_w[k] = r_data[k];
    for (int k = 0; k < LANES; k++)
      if (CNTW'(k) < c_cnt_p1) comb_w[k + int'(r_cnt)] = c_data_p1[lane_lo(k, WIDTH) +: WIDTH];
  end

  always_comb begin
    emit      = 1'b0;
    e_data    = '0;
    e_cnt     = '0;
    e_last    = 1'b0;
    r_load    = 1'b0;
    r_nxt     = r_data;
    r_cnt_nxt = r_cnt;
    state_nxt = state;
    if (state == S_FLUSH) begin
      if (o_free) begin
        emit      = 1'b1;
        e_cnt     = r_cnt;
        e_last    = 1'b1;
        r_cnt_nxt = '0;
        state_nxt = S_RUN;
        for (int k = 0; k < LANES; k++)
          if (CNTW'(k) < r_cnt) e_data[lane_lo(k, WIDTH) +: WIDTH] = r_data[k];
      end
    end else if (consume) begin
      r_load = 1'b1;
      if (c_last_p1 && total <= TW'(LANES)) begin
        emit      = 1'b1;
        e_cnt     = CNTW'(total);
        e_last    = 1'b1;
        r_cnt_nxt = '0;
        for (int k = 0; k < LANES; k++) e_data[lane_lo(k, WIDTH) +: WIDTH] = comb_w[k];
      end else if (total < TW'(LANES)) begin
        r_cnt_nxt = CNTW'(total);
        for (int k = 0; k < LANES; k++) r_nxt[k] = comb_w[k];
      end else begin
        emit      = 1'b1;
        e_cnt     = CNTW'(LANES);
        r_cnt_nxt = CNTW'(total - TW'(LANES));
        for (int k = 0; k < LANES; k++) begin
          e_data[lane_lo(k, WIDTH) +: WIDTH] = comb_w[k];
          r_nxt[k] = comb_w[LANES + k];
        end
        if (c_last_p1) state_nxt = S_FLUSH;
      end
    end
  end

  // Stage C (p1) and stage O (p2) control, plus the residual count and FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      data_p2 <= '0;
      cnt_p2  <= '0;
      last_p2 <= 1'b0;
      r_cnt   <= '0;
      state   <= S_RUN;
    end else begin
      if (accept) vld_p1 <= 1'b1;
      else if (consume) vld_p1 <= 1'b0;
      if (emit) begin
        vld_p2  <= 1'b1;
        data_p2 <= e_data;
        cnt_p2  <= e_cnt;
        last_p2 <= e_last;
      end else if (bus.out_ready) begin
        vld_p2 <= 1'b0;
      end
      r_cnt <= r_cnt_nxt;
      state <= state_nxt;
    end
  end

  // Datapath registers; their contents are only meaningful under vld_p1 / r_cnt
  always_ff @(posedge clk) begin
    if (accept) begin
      c_data_p1 <= cdata;
      c_cnt_p1  <= ccount;
      c_last_p1 <= bus.in_last;
    end
    if (r_load) r_data <= r_nxt;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_p2;
  assign bus.out_data  = data_p2;
  assign bus.out_count = cnt_p2;
  assign bus.out_last  = last_p2;

endmodule

// File: tb/tb_filter_compact_pack.sv
// Bench for filter_compact_pack: directed scenarios plus randomized streams against a word-queue model.
module tb_filter_compact_pack;
  localparam int L = 4;
  localparam int W = 64;

  typedef struct {
    logic [L*W-1:0] data;
    int             cnt;
    bit             last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  filter_compact_pack_if #(.LANES(L), .WIDTH(W)) bus ();
  filter_compact_pack #(.LANES(L), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int           checks = 0;
  int           errors = 0;
  beat_t        got_q[$];
  beat_t        exp_q[$];
  logic [W-1:0] mq[$];
  beat_t        mon_b;

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      mon_b.data = bus.out_data;
      mon_b.cnt  = int'(bus.out_count);
      mon_b.last = bus.out_last;
      got_q.push_back(mon_b);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [L*W-1:0] pack4(input logic [W-1:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  // Reference model: a plain FIFO of words cut into LANES-sized beats
  function automatic void model_emit(input int n, input bit last);
    beat_t b;
    b.data = '0;
    b.cnt  = n;
    b.last = last;
    for (int k = 0; k < n; k++) b.data[k*W +: W] = mq.pop_front();
    exp_q.push_back(b);
  endfunction

  function automatic void model_push(input logic [L-1:0] m, input logic [L*W-1:0] d, input bit last);
    int n;
    for (int i = 0; i < L; i++) if (m[i]) mq.push_back(d[i*W +: W]);
    if (!last) begin
      while (mq.size() >= L) model_emit(L, 1'b0);
    end else if (mq.size() == 0) begin
      model_emit(0, 1'b1);
    end else begin
      while (mq.size() > 0) begin
        n = (mq.size() < L) ? mq.size() : L;
        model_emit(n, mq.size() == n);
      end
    end
  endfunction

  function automatic logic [L*W-1:0] rand_data();
    logic [L*W-1:0] d;
    for (int k = 0; k < L; k++) d[k*W +: W] = {$urandom(), $urandom()};
    return d;
  endfunction

  task automatic send_beat(input logic [L-1:0] m, input logic [L*W-1:0] d, input bit last);
    int c;
    bus.in_valid = 1'b1;
    bus.in_mask  = m;
    bus.in_data  = d;
    bus.in_last  = last;
    c = 0;
    @(negedge clk);
    while (!bus.in_ready && c < 300) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout in_ready=%b required=1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    model_push(m, d, last);
  endtask

  task automatic clear_all();
    got_q.delete();
    exp_q.delete();
    mq.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_in_ready got=%b required=0", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_count !== '0 || bus.out_data !== '0) begin
      errors++;
      $display("FAIL rst_outputs valid=%b last=%b count=%0d data=%h required all 0",
               bus.out_valid, bus.out_last, bus.out_count, bus.out_data);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL post_rst in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    logic [L*W-1:0] d;
    clear_all();
    bus.out_ready = 1'b1;
    d = pack4(64'h10, 64'h11, 64'h12, 64'h13);
    bus.in_valid = 1'b1; bus.in_mask = 4'b1111; bus.in_data = d; bus.in_last = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL lat_ready got=%b required=1", bus.in_ready);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0; bus.in_last = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL lat_cycle1 out_valid=%b required=0", bus.out_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_count !== 3'd4 || bus.out_last !== 1'b1 || bus.out_data !== d) begin
      errors++;
      $display("FAIL lat_cycle2 valid=%b count=%0d last=%b data=%h required 1/4/1/%h",
               bus.out_valid, bus.out_count, bus.out_last, bus.out_data, d);
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_three_beats();
    beat_t e[2];
    clear_all();
    bus.out_ready = 1'b1;
    send_beat(4'b0101, pack4(64'hA0, 64'hBAD1, 64'hA2, 64'hBAD3), 1'b0);
    send_beat(4'b1111, pack4(64'hB0, 64'hB1, 64'hB2, 64'hB3), 1'b0);
    send_beat(4'b0001, pack4(64'hC0, 64'hBAD5, 64'hBAD6, 64'hBAD7), 1'b1);
    e[0] = '{pack4(64'hA0, 64'hA2, 64'hB0, 64'hB1), 4, 1'b0};
    e[1] = '{pack4(64'hB2, 64'hB3, 64'hC0, 64'h0), 3, 1'b1};
    for (int c = 0; c < 200 && got_q.size() < 2; c++) @(negedge clk);
    repeat (4) @(negedge clk);
    checks++;
    if (got_q.size() !== 2) begin
      errors++; $display("FAIL three_nbeats got=%0d required=2", got_q.size());
    end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].data !== e[i].data || got_q[i].cnt !== e[i].cnt || got_q[i].last !== e[i].last) begin
        errors++;
        $display("FAIL three_beat%0d got=%h/%0d/%b required=%h/%0d/%b", i,
                 got_q[i].data, got_q[i].cnt, got_q[i].last, e[i].data, e[i].cnt, e[i].last);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_overflow_last();
    beat_t e[2];
    clear_all();
    bus.out_ready = 1'b1;
    send_beat(4'b0111, pack4(64'h20, 64'h21, 64'h22, 64'hBAD0), 1'b0);
    send_beat(4'b1111, pack4(64'h30, 64'h31, 64'h32, 64'h33), 1'b1);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_in_ready got=%b required=0", bus.in_ready);
    end
    e[0] = '{pack4(64'h20, 64'h21, 64'h22, 64'h30), 4, 1'b0};
    e[1] = '{pack4(64'h31, 64'h32, 64'h33, 64'h0), 3, 1'b1};
    for (int c = 0; c < 200 && got_q.size() < 2; c++) @(negedge clk);
    repeat (4) @(negedge clk);
    checks++;
    if (got_q.size() !== 2) begin
      errors++; $display("FAIL ovf_nbeats got=%0d required=2", got_q.size());
    end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].data !== e[i].data || got_q[i].cnt !== e[i].cnt || got_q[i].last !== e[i].last) begin
        errors++;
        $display("FAIL ovf_beat%0d got=%h/%0d/%b required=%h/%0d/%b", i,
                 got_q[i].data, got_q[i].cnt, got_q[i].last, e[i].data, e[i].cnt, e[i].last);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_empty_last();
    clear_all();
    bus.out_ready = 1'b1;
    send_beat(4'b0000, pack4(64'hBAD0, 64'hBAD1, 64'hBAD2, 64'hBAD3), 1'b1);
    for (int c = 0; c < 200 && got_q.size() < 1; c++) @(negedge clk);
    repeat (4) @(negedge clk);
    checks++;
    if (got_q.size() !== 1) begin
      errors++; $display("FAIL empty_nbeats got=%0d required=1", got_q.size());
    end else begin
      checks++;
      if (got_q[0].data !== '0 || got_q[0].cnt !== 0 || got_q[0].last !== 1'b1) begin
        errors++;
        $display("FAIL empty_beat got=%h/%0d/%b required=0/0/1", got_q[0].data, got_q[0].cnt, got_q[0].last);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_exact_multiple();
    beat_t e[2];
    clear_all();
    bus.out_ready = 1'b1;
    send_beat(4'b1111, pack4(64'h40, 64'h41, 64'h42, 64'h43), 1'b0);
    send_beat(4'b1111, pack4(64'h50, 64'h51, 64'h52, 64'h53), 1'b1);
    e[0] = '{pack4(64'h40, 64'h41, 64'h42, 64'h43), 4, 1'b0};
    e[1] = '{pack4(64'h50, 64'h51, 64'h52, 64'h53), 4, 1'b1};
    for (int c = 0; c < 200 && got_q.size() < 2; c++) @(negedge clk);
    repeat (6) @(negedge clk);
    checks++;
    if (got_q.size() !== 2) begin
      errors++; $display("FAIL exact_nbeats got=%0d required=2", got_q.size());
    end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].data !== e[i].data || got_q[i].cnt !== e[i].cnt || got_q[i].last !== e[i].last) begin
        errors++;
        $display("FAIL exact_beat%0d got=%h/%0d/%b required=%h/%0d/%b", i,
                 got_q[i].data, got_q[i].cnt, got_q[i].last, e[i].data, e[i].cnt, e[i].last);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    bit                 saw_block;
    bit                 have;
    int                 unstable;
    logic [L*W-1:0]     s_data;
    logic [2:0]         s_cnt;
    logic               s_last;
    clear_all();
    saw_block = 1'b0; have = 1'b0; unstable = 0;
    s_data = '0; s_cnt = '0; s_last = 1'b0;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int b = 0; b < 6; b++)
          send_beat(4'($urandom()) | 4'b0001, rand_data(), b == 5);
      end
      begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (bus.in_ready === 1'b0) saw_block = 1'b1;
          if (bus.out_valid === 1'b1) begin
            if (!have) begin
              have = 1'b1; s_data = bus.out_data; s_cnt = bus.out_count; s_last = bus.out_last;
            end else if (bus.out_data !== s_data || bus.out_count !== s_cnt || bus.out_last !== s_last) begin
              unstable++;
            end
          end
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    checks++;
    if (saw_block !== 1'b1) begin
      errors++; $display("FAIL bp_in_ready_drop seen=%b required=1", saw_block);
    end
    checks++;
    if (have !== 1'b1 || unstable !== 0) begin
      errors++; $display("FAIL bp_stable held=%b changes=%0d required 1/0", have, unstable);
    end
    for (int c = 0; c < 300 && got_q.size() < exp_q.size(); c++) @(negedge clk);
    repeat (6) @(negedge clk);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL bp_nbeats got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].data !== exp_q[i].data || got_q[i].cnt !== exp_q[i].cnt || got_q[i].last !== exp_q[i].last) begin
        errors++;
        $display("FAIL bp_beat%0d got=%h/%0d/%b required=%h/%0d/%b", i,
                 got_q[i].data, got_q[i].cnt, got_q[i].last, exp_q[i].data, exp_q[i].cnt, exp_q[i].last);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random_stream();
    bit done;
    clear_all();
    done = 1'b0;
    fork
      begin
        for (int s = 0; s < 3; s++)
          for (int b = 0; b < 12; b++)
            send_beat(4'($urandom()), rand_data(), b == 11);
        done = 1'b1;
      end
      begin
        for (int c = 0; c < 5000 && !done; c++) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    bus.out_ready = 1'b1;
    for (int c = 0; c < 300 && got_q.size() < exp_q.size(); c++) @(negedge clk);
    repeat (6) @(negedge clk);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL rnd_nbeats got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].data !== exp_q[i].data || got_q[i].cnt !== exp_q[i].cnt || got_q[i].last !== exp_q[i].last) begin
        errors++;
        $display("FAIL rnd_beat%0d got=%h/%0d/%b required=%h/%0d/%b", i,
                 got_q[i].data, got_q[i].cnt, got_q[i].last, exp_q[i].data, exp_q[i].cnt, exp_q[i].last);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    logic [L*W-1:0] d;
    clear_all();
    bus.out_ready = 1'b0;
    send_beat(4'b0011, pack4(64'h60, 64'h61, 64'hBAD2, 64'hBAD3), 1'b0);
    send_beat(4'b1111, pack4(64'h70, 64'h71, 64'h72, 64'h73), 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL rm_setup out_valid=%b required=1", bus.out_valid);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    clear_all();
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_count !== '0) begin
      errors++; $display("FAIL rm_outputs out_valid=%b out_count=%0d required 0/0", bus.out_valid, bus.out_count);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    d = pack4(64'h80, 64'h81, 64'h82, 64'h83);
    send_beat(4'b1111, d, 1'b1);
    for (int c = 0; c < 200 && got_q.size() < 1; c++) @(negedge clk);
    repeat (6) @(negedge clk);
    checks++;
    if (got_q.size() !== 1) begin
      errors++; $display("FAIL rm_nbeats got=%0d required=1", got_q.size());
    end else begin
      checks++;
      if (got_q[0].data !== d || got_q[0].cnt !== 4 || got_q[0].last !== 1'b1) begin
        errors++;
        $display("FAIL rm_beat got=%h/%0d/%b required=%h/4/1", got_q[0].data, got_q[0].cnt, got_q[0].last, d);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_mask   = '0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_latency();
    test_three_beats();
    test_overflow_last();
    test_empty_last();
    test_exact_multiple();
    test_backpressure();
    test_random_stream();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
